// File: rtl/aes_pkg.sv
// Shared types, round counts and known-answer vectors for the AES self-test sequencer.
package aes_pkg;

    typedef enum logic [1:0] {
        MODE_128     = 2'b00,
        MODE_192     = 2'b01,
        MODE_256     = 2'b10,
        MODE_ILLEGAL = 2'b11
    } aes_mode_e;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_LOAD     = 4'd1,
        ST_ENC_REQ  = 4'd2,
        ST_ENC_WAIT = 4'd3,
        ST_DEC_REQ  = 4'd4,
        ST_DEC_WAIT = 4'd5,
        ST_CHECK    = 4'd6,
        ST_DONE     = 4'd7,
        ST_ERR      = 4'd8
    } seq_state_e;

    localparam logic [3:0] AES_NR_128 = 4'd10;
    localparam logic [3:0] AES_NR_192 = 4'd12;
    localparam logic [3:0] AES_NR_256 = 4'd14;

    // FIPS-197 appendix C vectors used by the known-answer test
    localparam logic [127:0] AES_KAT_PT     = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] AES_KAT_CT_128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] AES_KAT_CT_192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] AES_KAT_CT_256 = 128'h8ea2b7ca516745bfeafc49904b496089;

    function automatic logic [3:0] nr_of(input logic [1:0] mode);
        case (mode)
            MODE_128: nr_of = AES_NR_128;
            MODE_192: nr_of = AES_NR_192;
            MODE_256: nr_of = AES_NR_256;
            default:  nr_of = AES_NR_128;
        endcase
    endfunction

endpackage

// File: rtl/aes_round_timer.sv
// Watchdog down-counter: expires after TIMEOUT consecutive enabled cycles since the last clear.
module aes_round_timer #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int W = $clog2(TIMEOUT + 1);
    localparam logic [W-1:0] LOAD_VAL = W'(TIMEOUT - 1);

    logic [W-1:0] count_r;

    // Reload on clear, count down while enabled, saturate at zero
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_r <= LOAD_VAL;
        end else if (clear) begin
            count_r <= LOAD_VAL;
        end else if (enable && (count_r != '0)) begin
            count_r <= count_r - W'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign expired = enable && (count_r == '0);

endmodule

// File: rtl/aes_selftest_sequencer.sv
// Round sequencer for the AES known-answer self-test: encrypt Nr+1 steps, decrypt Nr+1 steps,
// compare both ends against the reference vectors, with single-step mode and a round watchdog.
module aes_selftest_sequencer
    import aes_pkg::*;
#(
    parameter int DATA_W  = 128,
    parameter int MAX_NR  = 14,
    parameter int CNT_W   = 5,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [1:0]        mode_sel,
    input  logic              step_mode,
    input  logic              step,
    input  logic [DATA_W-1:0] plain_text,
    input  logic [DATA_W-1:0] expected_enc,
    output logic              round_req,
    output logic              round_dir,
    output logic [3:0]        round_idx,
    input  logic              round_ack,
    input  logic [DATA_W-1:0] round_state,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              fail,
    output logic              err_timeout,
    output logic [DATA_W-1:0] disp_state,
    output logic [CNT_W-1:0]  disp_round
);

    localparam int IDX_W = $clog2(MAX_NR + 1);

    seq_state_e        state_r;
    seq_state_e        next_state_s;
    logic [IDX_W-1:0]  nr_r;
    logic [IDX_W-1:0]  round_idx_r;
    logic              round_dir_r;
    logic              round_req_r;
    logic              busy_r;
    logic              done_r;
    logic              pass_r;
    logic              fail_r;
    logic              err_timeout_r;
    logic              enc_ok_r;
    logic              dec_ok_r;
    logic [DATA_W-1:0] disp_state_r;
    logic [CNT_W-1:0]  disp_round_r;

    logic accept_s;
    logic illegal_s;
    logic ack_s;
    logic last_round_s;
    logic timeout_s;
    logic finish_s;
    logic in_wait_s;
    logic expired_s;

    assign in_wait_s    = (state_r == ST_ENC_WAIT) || (state_r == ST_DEC_WAIT);
    assign last_round_s = (round_idx_r == nr_r);

    aes_round_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (~in_wait_s | round_ack),
        .enable  (in_wait_s),
        .expired (expired_s)
    );

    // FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state decode and one-cycle control strobes
    always_comb begin
        next_state_s = state_r;
        accept_s     = 1'b0;
        illegal_s    = 1'b0;
        ack_s        = 1'b0;
        timeout_s    = 1'b0;
        finish_s     = 1'b0;
        case (state_r)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start && (mode_sel == MODE_ILLEGAL)) begin
                    illegal_s    = 1'b1;
                    next_state_s = ST_ERR;
                end else if (start) begin
                    accept_s     = 1'b1;
                    next_state_s = ST_LOAD;
                end else begin
                    next_state_s = state_r;
                end
            end
            ST_LOAD: next_state_s = ST_ENC_REQ;
            ST_ENC_REQ, ST_DEC_REQ: begin
                // step pulses only matter here; elsewhere they are dropped
                if (!step_mode || step) begin
                    next_state_s = (state_r == ST_ENC_REQ) ? ST_ENC_WAIT : ST_DEC_WAIT;
                end else begin
                    next_state_s = state_r;
                end
            end
            ST_ENC_WAIT, ST_DEC_WAIT: begin
                if (round_ack) begin
                    ack_s = 1'b1;
                    if (state_r == ST_ENC_WAIT) begin
                        next_state_s = last_round_s ? ST_DEC_REQ : ST_ENC_REQ;
                    end else begin
                        next_state_s = last_round_s ? ST_CHECK : ST_DEC_REQ;
                    end
                end else if (expired_s) begin
                    timeout_s    = 1'b1;
                    next_state_s = ST_ERR;
                end else begin
                    next_state_s = state_r;
                end
            end
            ST_CHECK: begin
                finish_s     = 1'b1;
                next_state_s = ST_DONE;
            end
            default: next_state_s = ST_IDLE;
        endcase
    end

    // Handshake, status flags and the sticky verdict registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            round_req_r   <= 1'b0;
            done_r        <= 1'b0;
            busy_r        <= 1'b0;
            pass_r        <= 1'b0;
            fail_r        <= 1'b0;
            err_timeout_r <= 1'b0;
            nr_r          <= '0;
        end else begin
            round_req_r <= (next_state_s == ST_ENC_WAIT) || (next_state_s == ST_DEC_WAIT);
            done_r      <= illegal_s | timeout_s | finish_s;
            if (accept_s) begin
                nr_r          <= IDX_W'(nr_of(mode_sel));
                busy_r        <= 1'b1;
                pass_r        <= 1'b0;
                fail_r        <= 1'b0;
                err_timeout_r <= 1'b0;
            end else if (illegal_s) begin
                pass_r        <= 1'b0;
                fail_r        <= 1'b1;
                err_timeout_r <= 1'b0;
            end else if (timeout_s) begin
                busy_r        <= 1'b0;
                fail_r        <= 1'b1;
                err_timeout_r <= 1'b1;
            end else if (finish_s) begin
                busy_r <= 1'b0;
                pass_r <= enc_ok_r & dec_ok_r;
                fail_r <= ~(enc_ok_r & dec_ok_r);
            end
        end
    end

    // Round position, display capture and per-direction result checks
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            round_idx_r  <= '0;
            round_dir_r  <= 1'b0;
            disp_state_r <= '0;
            disp_round_r <= '0;
            enc_ok_r     <= 1'b0;
            dec_ok_r     <= 1'b0;
        end else if (accept_s) begin
            enc_ok_r <= 1'b0;
            dec_ok_r <= 1'b0;
        end else if (state_r == ST_LOAD) begin
            disp_state_r <= plain_text;
            disp_round_r <= '0;
            round_idx_r  <= '0;
            round_dir_r  <= 1'b0;
        end else if (ack_s) begin
            disp_state_r <= round_state;
            disp_round_r <= disp_round_r + CNT_W'(1);
            if (!last_round_s) begin
                round_idx_r <= round_idx_r + IDX_W'(1);
            end else if (state_r == ST_ENC_WAIT) begin
                // decryption always follows, even on a ciphertext mismatch
                enc_ok_r    <= (round_state == expected_enc);
                round_idx_r <= '0;
                round_dir_r <= 1'b1;
            end else begin
                dec_ok_r <= (round_state == plain_text);
            end
        end
    end

    assign round_req   = round_req_r;
    assign round_dir   = round_dir_r;
    assign round_idx   = 4'(round_idx_r);
    assign busy        = busy_r;
    assign done        = done_r;
    assign pass        = pass_r;
    assign fail        = fail_r;
    assign err_timeout = err_timeout_r;
    assign disp_state  = disp_state_r;
    assign disp_round  = disp_round_r;

endmodule

// File: tb/tb_aes_selftest_sequencer.sv
// Directed bench for aes_selftest_sequencer with a reactive round-datapath model.
module tb_aes_selftest_sequencer;

    localparam logic [127:0] PT    = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         start;
    logic [1:0]   mode_sel;
    logic         step_mode;
    logic         step;
    logic [127:0] plain_text;
    logic [127:0] expected_enc;
    logic         round_req;
    logic         round_dir;
    logic [3:0]   round_idx;
    logic         round_ack;
    logic [127:0] round_state;
    logic         busy;
    logic         done;
    logic         pass;
    logic         fail;
    logic         err_timeout;
    logic [127:0] disp_state;
    logic [4:0]   disp_round;

    int checks = 0;
    int errors = 0;

    // datapath model controls and bookkeeping
    int           ack_delay     = 1;
    int           corrupt_step  = 0;
    int           withhold_step = 0;
    int           nr_exp        = 10;
    int           acks          = 0;
    int           wait_cnt      = 0;
    logic         ack_pending   = 1'b0;
    logic [127:0] sent_state    = '0;
    logic [127:0] final_ct      = '0;

    aes_selftest_sequencer dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .mode_sel     (mode_sel),
        .step_mode    (step_mode),
        .step         (step),
        .plain_text   (plain_text),
        .expected_enc (expected_enc),
        .round_req    (round_req),
        .round_dir    (round_dir),
        .round_idx    (round_idx),
        .round_ack    (round_ack),
        .round_state  (round_state),
        .busy         (busy),
        .done         (done),
        .pass         (pass),
        .fail         (fail),
        .err_timeout  (err_timeout),
        .disp_state   (disp_state),
        .disp_round   (disp_round)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Round datapath model: acks after ack_delay wait cycles, verifies direction/index and capture
    initial begin
        round_ack   = 1'b0;
        round_state = '0;
        forever begin
            @(negedge clk);
            if (ack_pending) begin
                ack_pending = 1'b0;
                round_ack   = 1'b0;
                chk("disp_state", disp_state, sent_state);
                chk("disp_round", 128'(disp_round), 128'(acks));
                chk("req_drop", 128'(round_req), 128'd0);
            end else if (round_req && reset_n) begin
                wait_cnt++;
                if (wait_cnt >= ack_delay && (acks + 1) != withhold_step) begin
                    int k;
                    k = acks + 1;
                    if (k <= nr_exp + 1) begin
                        chk("round_dir", 128'(round_dir), 128'd0);
                        chk("round_idx", 128'(round_idx), 128'(k - 1));
                    end else begin
                        chk("round_dir", 128'(round_dir), 128'd1);
                        chk("round_idx", 128'(round_idx), 128'(k - nr_exp - 2));
                    end
                    if (k == nr_exp + 1)           sent_state = final_ct;
                    else if (k == 2 * nr_exp + 2)  sent_state = PT;
                    else                           sent_state = {4{32'hc0de0000 + 32'(k)}};
                    if (k == corrupt_step) sent_state = sent_state ^ 128'h1;
                    round_state = sent_state;
                    round_ack   = 1'b1;
                    acks        = k;
                    ack_pending = 1'b1;
                    wait_cnt    = 0;
                end
            end
        end
    end

    task automatic run_test(input logic [1:0] mode, input int delay, input int corrupt,
                            input int withhold, input logic disturb, input logic exp_pass,
                            input logic exp_to, input int exp_round);
        int cyc;
        ack_delay     = delay;
        corrupt_step  = corrupt;
        withhold_step = withhold;
        acks          = 0;
        wait_cnt      = 0;
        nr_exp        = (mode == 2'b00) ? 10 : (mode == 2'b01) ? 12 : 14;
        final_ct      = (mode == 2'b00) ? CT128 : (mode == 2'b01) ? CT192 : CT256;
        expected_enc  = final_ct;
        mode_sel      = mode;
        start         = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_start", 128'(busy), 128'd1);
        cyc = 0;
        while (!done && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            if (disturb && cyc == 5) begin
                start    = 1'b1;
                mode_sel = 2'b11;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        chk("done_seen", 128'(done), 128'd1);
        chk("pass", 128'(pass), 128'(exp_pass));
        chk("fail", 128'(fail), 128'(!exp_pass));
        chk("err_timeout", 128'(err_timeout), 128'(exp_to));
        chk("busy_end", 128'(busy), 128'd0);
        chk("req_end", 128'(round_req), 128'd0);
        chk("final_round", 128'(disp_round), 128'(exp_round));
        chk("ack_count", 128'(acks), 128'(exp_round));
        if (exp_to) chk("wait_cycles", 128'(wait_cnt), 128'd15);
        @(negedge clk);
        chk("done_pulse", 128'(done), 128'd0);
        chk("round_hold", 128'(disp_round), 128'(exp_round));
        mode_sel = 2'b00;
    endtask

    initial begin
        reset_n      = 1'b0;
        start        = 1'b0;
        mode_sel     = 2'b00;
        step_mode    = 1'b0;
        step         = 1'b0;
        plain_text   = PT;
        expected_enc = CT128;
        repeat (3) @(negedge clk);
        chk("reset_ctl", 128'({round_req, round_dir, round_idx, busy, done, pass, fail, err_timeout}), 128'd0);
        chk("reset_disp", disp_state, 128'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // 1: AES-128, fast ack
        run_test(2'b00, 1, 0, 0, 1'b0, 1'b1, 1'b0, 22);
        chk("ct128_final", disp_state, PT);
        // 2: AES-192 / AES-256, ack after 3 wait cycles
        run_test(2'b01, 3, 0, 0, 1'b0, 1'b1, 1'b0, 26);
        run_test(2'b10, 3, 0, 0, 1'b0, 1'b1, 1'b0, 30);
        // 3: corrupted final encryption round
        run_test(2'b00, 1, 11, 0, 1'b0, 1'b0, 1'b0, 22);
        // 4: withheld ack triggers the watchdog, then a clean rerun
        run_test(2'b00, 1, 0, 5, 1'b0, 1'b0, 1'b1, 4);
        run_test(2'b00, 1, 0, 0, 1'b0, 1'b1, 1'b0, 22);
        // ack landing in the expiry cycle completes the round
        run_test(2'b00, 15, 0, 0, 1'b0, 1'b1, 1'b0, 22);

        // 6: illegal mode, then start/mode_sel disturbance during a 192-bit run
        mode_sel = 2'b11;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("illegal_done", 128'(done), 128'd1);
        chk("illegal_fail", 128'(fail), 128'd1);
        chk("illegal_pass", 128'(pass), 128'd0);
        chk("illegal_busy", 128'(busy), 128'd0);
        chk("illegal_req", 128'(round_req), 128'd0);
        repeat (3) @(negedge clk);
        chk("illegal_noreq", 128'(round_req), 128'd0);
        run_test(2'b01, 1, 0, 0, 1'b1, 1'b1, 1'b0, 26);

        // 5: single-step mode, seven steps, then asynchronous reset mid-run
        step_mode     = 1'b1;
        ack_delay     = 1;
        corrupt_step  = 0;
        withhold_step = 0;
        nr_exp        = 10;
        final_ct      = CT128;
        expected_enc  = CT128;
        acks          = 0;
        wait_cnt      = 0;
        mode_sel      = 2'b00;
        start         = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        chk("step_hold", 128'(disp_round), 128'd0);
        for (int i = 0; i < 7; i++) begin
            step = 1'b1;
            @(negedge clk);
            step = 1'b0;
            repeat (4) @(negedge clk);
        end
        chk("step_round", 128'(disp_round), 128'd7);
        chk("step_busy", 128'(busy), 128'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("areset_ctl", 128'({round_req, round_dir, round_idx, busy, done, pass, fail, err_timeout}), 128'd0);
        chk("areset_disp", disp_state, 128'd0);
        chk("areset_round", 128'(disp_round), 128'd0);
        @(negedge clk);
        reset_n   = 1'b1;
        step_mode = 1'b0;
        repeat (4) @(negedge clk);
        chk("idle_after_reset", 128'({round_req, busy, done}), 128'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
